// File: rtl/bch_pkg.sv
// Shared GF(2^5) arithmetic, BCH(31,21) constants, result codes and FSM states
// for the double-error-correcting BCH decoder.
package bch_pkg;

    localparam int          GF_W     = 5;
    localparam logic [5:0]  GF_POLY  = 6'b100101;      // x^5 + x^2 + 1
    localparam logic [4:0]  GF_RED   = 5'b00101;       // GF_POLY without the x^5 term
    localparam logic [10:0] G_POLY   = 11'h769;        // x^10+x^9+x^8+x^6+x^5+x^3+1
    localparam int          CW_N     = 31;

    localparam logic [4:0]  ALPHA      = 5'b00010;
    localparam logic [4:0]  ALPHA_INV  = 5'b10010;     // alpha^-1 = alpha^4 + alpha
    localparam logic [4:0]  ALPHA_INV2 = 5'b01001;     // alpha^-2 = alpha^3 + 1

    localparam logic [1:0]  ERR_NONE   = 2'd0;
    localparam logic [1:0]  ERR_ONE    = 2'd1;
    localparam logic [1:0]  ERR_TWO    = 2'd2;
    localparam logic [1:0]  ERR_UNCORR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYND,
        ST_SOLVE,
        ST_CHIEN,
        ST_DONE
    } state_t;

    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        logic [4:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < GF_W; k++) begin
            if (b[k]) p = p ^ x;
            x = x[4] ? ({x[3:0], 1'b0} ^ GF_RED) : {x[3:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [4:0] gf_sq(input logic [4:0] a);
        return gf_mul(a, a);
    endfunction

    // a^-1 = a^30 = a^2 * a^4 * a^8 * a^16; maps 0 to 0.
    function automatic logic [4:0] gf_inv(input logic [4:0] a);
        logic [4:0] a2, a4, a8, a16;
        a2  = gf_sq(a);
        a4  = gf_sq(a2);
        a8  = gf_sq(a4);
        a16 = gf_sq(a8);
        return gf_mul(gf_mul(a2, a4), gf_mul(a8, a16));
    endfunction

    // Elaboration-time helper for constant power tables.
    function automatic logic [4:0] gf_alpha_pow(input int e);
        logic [4:0] p;
        p = 5'b00001;
        for (int k = 0; k < e; k++) p = gf_mul(p, ALPHA);
        return p;
    endfunction

endpackage

// File: rtl/bch_synd_31.sv
// Combinational syndrome pair S1 = r(alpha), S3 = r(alpha^3) of a 31-bit word.
module bch_synd_31
    import bch_pkg::*;
(
    input  logic [30:0] cw,
    output logic [4:0]  s1,
    output logic [4:0]  s3
);

    logic [30:0][4:0] term1;
    logic [30:0][4:0] term3;

    genvar gi;
    generate
        for (gi = 0; gi < CW_N; gi++) begin : g_term
            localparam logic [4:0] P1 = gf_alpha_pow(gi);
            localparam logic [4:0] P3 = gf_alpha_pow((3 * gi) % CW_N);
            assign term1[gi] = cw[gi] ? P1 : 5'd0;
            assign term3[gi] = cw[gi] ? P3 : 5'd0;
        end
    endgenerate

    always_comb begin
        s1 = '0;
        s3 = '0;
        for (int k = 0; k < CW_N; k++) begin
            s1 = s1 ^ term1[k];
            s3 = s3 ^ term3[k];
        end
    end

endmodule

// File: rtl/bch_dec_correct.sv
// Shortened BCH(31,21) DEC decoder: syndrome, locator solve, 31-cycle Chien search.
// Optional macro BCH_DEC_EARLY_EXIT_EN sends error-free words straight to DONE.
module bch_dec_correct
    import bch_pkg::*;
#(
    parameter int P_D_WIDTH = 21
)
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [P_D_WIDTH+9:0]   cw_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [P_D_WIDTH-1:0]   d_o,
    output logic [1:0]             err_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    localparam int CW_W = P_D_WIDTH + 10;

    state_t                 state_reg, state_next;
    logic [30:0]            cw_reg, cw_next;
    logic [30:0]            fix_reg, fix_next;
    logic [4:0]             s1_reg, s1_next;
    logic [4:0]             s3_reg, s3_next;
    logic [4:0]             sig1_reg, sig1_next;
    logic [4:0]             sig2_reg, sig2_next;
    logic [1:0]             deg_reg, deg_next;
    logic                   uncorr_reg, uncorr_next;
    logic [4:0]             idx_reg, idx_next;
    logic [1:0]             root_cnt_reg, root_cnt_next;
    logic                   bad_root_reg, bad_root_next;
    logic [P_D_WIDTH-1:0]   d_reg, d_next;
    logic [1:0]             err_reg, err_next;

    logic [4:0]             s1_c, s3_c, s1_cube;
    logic                   root_hit, bad_now;
    logic [1:0]             cnt_now;
    logic [30:0]            fix_now;

    bch_synd_31 u_synd (
        .cw (cw_reg),
        .s1 (s1_c),
        .s3 (s3_c)
    );

    assign s1_cube     = gf_mul(gf_sq(s1_reg), s1_reg);
    assign in_ready_o  = (state_reg == ST_IDLE);
    assign out_valid_o = (state_reg == ST_DONE);
    assign d_o         = d_reg;
    assign err_o       = err_reg;

    always_comb begin
        state_next    = state_reg;
        cw_next       = cw_reg;
        fix_next      = fix_reg;
        s1_next       = s1_reg;
        s3_next       = s3_reg;
        sig1_next     = sig1_reg;
        sig2_next     = sig2_reg;
        deg_next      = deg_reg;
        uncorr_next   = uncorr_reg;
        idx_next      = idx_reg;
        root_cnt_next = root_cnt_reg;
        bad_root_next = bad_root_reg;
        d_next        = d_reg;
        err_next      = err_reg;

        // In CHIEN the sigma registers hold sigma1*alpha^-i and sigma2*alpha^-2i.
        root_hit = (state_reg == ST_CHIEN) && ((5'd1 ^ sig1_reg ^ sig2_reg) == 5'd0);
        cnt_now  = root_cnt_reg + {1'b0, root_hit};
        bad_now  = bad_root_reg | (root_hit && (idx_reg >= 5'(CW_W)));
        fix_now  = fix_reg ^ (root_hit ? (31'd1 << idx_reg) : 31'd0);

        case (state_reg)
            ST_IDLE: begin
                if (in_valid_i) begin
                    cw_next    = 31'(cw_i);
                    fix_next   = 31'(cw_i);
                    state_next = ST_SYND;
                end
            end
            ST_SYND: begin
                s1_next    = s1_c;
                s3_next    = s3_c;
                state_next = ST_SOLVE;
`ifdef BCH_DEC_EARLY_EXIT_EN
                if ((s1_c == 5'd0) && (s3_c == 5'd0)) begin
                    d_next     = cw_reg[CW_W-1:10];
                    err_next   = ERR_NONE;
                    state_next = ST_DONE;
                end
`endif
            end
            ST_SOLVE: begin
                sig1_next     = 5'd0;
                sig2_next     = 5'd0;
                deg_next      = 2'd0;
                uncorr_next   = 1'b0;
                idx_next      = 5'd0;
                root_cnt_next = 2'd0;
                bad_root_next = 1'b0;
                if (s1_reg == 5'd0) begin
                    uncorr_next = (s3_reg != 5'd0);
                end else if (s3_reg == s1_cube) begin
                    sig1_next = s1_reg;
                    deg_next  = 2'd1;
                end else begin
                    sig1_next = s1_reg;
                    sig2_next = gf_mul(s3_reg ^ s1_cube, gf_inv(s1_reg));
                    deg_next  = 2'd2;
                end
                state_next = ST_CHIEN;
            end
            ST_CHIEN: begin
                sig1_next     = gf_mul(sig1_reg, ALPHA_INV);
                sig2_next     = gf_mul(sig2_reg, ALPHA_INV2);
                fix_next      = fix_now;
                root_cnt_next = cnt_now;
                bad_root_next = bad_now;
                idx_next      = idx_reg + 5'd1;
                if (idx_reg == 5'(CW_N - 1)) begin
                    if (uncorr_reg || (cnt_now != deg_reg) || bad_now) begin
                        d_next   = cw_reg[CW_W-1:10];
                        err_next = ERR_UNCORR;
                    end else begin
                        d_next   = fix_now[CW_W-1:10];
                        err_next = deg_reg;
                    end
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            cw_reg       <= '0;
            fix_reg      <= '0;
            s1_reg       <= '0;
            s3_reg       <= '0;
            sig1_reg     <= '0;
            sig2_reg     <= '0;
            deg_reg      <= '0;
            uncorr_reg   <= 1'b0;
            idx_reg      <= '0;
            root_cnt_reg <= '0;
            bad_root_reg <= 1'b0;
            d_reg        <= '0;
            err_reg      <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            cw_reg       <= cw_next;
            fix_reg      <= fix_next;
            s1_reg       <= s1_next;
            s3_reg       <= s3_next;
            sig1_reg     <= sig1_next;
            sig2_reg     <= sig2_next;
            deg_reg      <= deg_next;
            uncorr_reg   <= uncorr_next;
            idx_reg      <= idx_next;
            root_cnt_reg <= root_cnt_next;
            bad_root_reg <= bad_root_next;
            d_reg        <= d_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_bch_dec_correct.sv
// Directed bench for bch_dec_correct (default build, 21-bit data).
module tb_bch_dec_correct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [30:0] cw = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] d;
    logic [1:0]  err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bch_dec_correct #(.P_D_WIDTH(21)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cw_i        (cw),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .d_o         (d),
        .err_o       (err),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    // Presents one word for one edge, then counts edges (the accepting edge is 1)
    // until out_valid is seen; gives up at 200 and returns that value.
    task automatic send_word(input logic [30:0] w, output int lat);
        cw = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("word cw=%h lat=%0d d=%h err=%0d", w, lat, d, err);
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (d !== 21'h0) begin bad++; $display("FAIL reset_d got %h want 000000", d); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL reset_err got %0d want 0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        int lat;
        send_word(31'h00000769, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL clean_latency got %0d want 34", lat); end
        total++; if (d !== 21'h000001) begin bad++; $display("FAIL clean_d got %h want 000001", d); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL clean_err got %0d want 0", err); end
        release_word();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clean_idle got %b want 1", in_ready); end
        send_word(31'h00000000, lat);
        total++; if (d !== 21'h000000 || err !== 2'd0) begin bad++; $display("FAIL zero_word got d=%h err=%0d want 000000/0", d, err); end
        release_word();
    endtask

    task automatic test_single();
        logic [30:0] vec_cw [3];
        logic [20:0] vec_d  [3];
        int lat;
        vec_cw[0] = 31'h00008769; vec_d[0] = 21'h000001;   // bit 15 of data-1 word
        vec_cw[1] = 31'h00000001; vec_d[1] = 21'h000000;   // parity bit 0 of zero word
        vec_cw[2] = 31'h00100000; vec_d[2] = 21'h000000;   // data bit 10 of zero word
        for (int i = 0; i < 3; i++) begin
            send_word(vec_cw[i], lat);
            total++; if (lat !== 34) begin bad++; $display("FAIL single_latency[%0d] got %0d want 34", i, lat); end
            total++; if (d !== vec_d[i]) begin bad++; $display("FAIL single_d[%0d] got %h want %h", i, d, vec_d[i]); end
            total++; if (err !== 2'd1) begin bad++; $display("FAIL single_err[%0d] got %0d want 1", i, err); end
            release_word();
        end
    endtask

    task automatic test_double();
        int lat;
        send_word(31'h40000369, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL double_latency got %0d want 34", lat); end
        total++; if (d !== 21'h000001) begin bad++; $display("FAIL double_d got %h want 000001", d); end
        total++; if (err !== 2'd2) begin bad++; $display("FAIL double_err got %0d want 2", err); end
        release_word();
    endtask

    task automatic test_uncorr();
        int lat;
        send_word(31'h0000076E, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL uncorr_latency got %0d want 34", lat); end
        total++; if (d !== 21'h000001) begin bad++; $display("FAIL uncorr_d got %h want 000001", d); end
        total++; if (err !== 2'd3) begin bad++; $display("FAIL uncorr_err got %0d want 3", err); end
        release_word();
    endtask

    task automatic test_hold();
        int lat;
        send_word(31'h00008769, lat);
        // A competing word is offered while the result waits; it must be ignored.
        cw = 31'h00000000;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got %b want 1", c, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got %b want 0", c, in_ready); end
            total++; if (d !== 21'h000001 || err !== 2'd1) begin bad++; $display("FAIL hold_data[%0d] got d=%h err=%0d want 000001/1", c, d, err); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_word();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_idle got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        send_word(31'h00008769, lat);
        total++; if (d !== 21'h000001 || err !== 2'd1 || lat !== 34) begin bad++; $display("FAIL b2b_first got d=%h err=%0d lat=%0d want 000001/1/34", d, err, lat); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b want 1", in_ready); end
        send_word(31'h40000369, lat);
        total++; if (d !== 21'h000001 || err !== 2'd2 || lat !== 34) begin bad++; $display("FAIL b2b_second got d=%h err=%0d lat=%0d want 000001/2/34", d, err, lat); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        int lat;
        cw = 31'h00008769;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Edges 2..13 after acceptance bring the Chien search to position 10.
        repeat (12) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        total++; if (d !== 21'h0 || err !== 2'd0) begin bad++; $display("FAIL abort_outputs got d=%h err=%0d want 000000/0", d, err); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
        $display("abort after chien position 10: valid cycles seen=%0d", seen);
        send_word(31'h00000769, lat);
        total++; if (d !== 21'h000001 || err !== 2'd0 || lat !== 34) begin bad++; $display("FAIL abort_recover got d=%h err=%0d lat=%0d want 000001/0/34", d, err, lat); end
        release_word();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_uncorr();
        test_hold();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bch_dec_correct.md
BCH_DEC_CORRECT -- requirements
Module: bch_dec_correct

Interface
REQ-001 The block SHALL have parameter P_D_WIDTH, default 21, giving the data width of a shortened BCH(31,21) double-error-correcting (DEC) code; legal values are 1..21.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cw_i, input, P_D_WIDTH+10 bits: received codeword = {data, parity[9:0]}; bit k is the coefficient of x^k.
REQ-005 The block SHALL have port in_valid_i, input, 1 bit: cw_i is valid.
REQ-006 The block SHALL have port in_ready_o, output, 1 bit: the block accepts a codeword.
REQ-007 The block SHALL have port d_o, output, P_D_WIDTH bits: corrected data.
REQ-008 The block SHALL have port err_o, output, 2 bits: 0 = no error, 1 = one bit corrected, 2 = two bits corrected, 3 = uncorrectable.
REQ-009 The block SHALL have port out_valid_o, output, 1 bit: d_o and err_o are valid.
REQ-010 The block SHALL have port out_ready_i, input, 1 bit: the downstream consumer takes the result.

Function
REQ-011 Field arithmetic SHALL use GF(2^5), primitive polynomial x^5+x^2+1, alpha = 5'b00010; the code generator is g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1.
REQ-012 The internal codeword SHALL be 31 bits, formed as cw_i zero-extended at the MSB end.
REQ-013 The FSM SHALL have states IDLE, SYND, SOLVE, CHIEN and DONE; in_ready_o = 1 only in IDLE.
REQ-014 A handshake in IDLE (in_valid_i & in_ready_o) SHALL register the codeword and move the FSM to SYND.
REQ-015 SYND SHALL last 1 cycle and register S1 = r(alpha) and S3 = r(alpha^3).
REQ-016 SOLVE SHALL last 1 cycle and register the locator as follows:
- S1=0, S3=0: deg 0.
- S1!=0, S3=S1^3: sigma1 = S1, sigma2 = 0, deg 1.
- S1!=0, S3!=S1^3: sigma1 = S1, sigma2 = (S3+S1^3)*S1^-1, deg 2.
- S1=0, S3!=0: uncorrectable.
REQ-017 CHIEN SHALL last exactly 31 cycles, evaluating position i = 0..30, one position per cycle.
REQ-018 In CHIEN, when 1 + sigma1*alpha^-i + sigma2*alpha^-2i = 0, the block SHALL flip bit i of the codeword and increment a root counter.
REQ-019 At CHIEN exit, the result SHALL be uncorrectable if root count != deg, or if any root lies at i >= P_D_WIDTH+10.
REQ-020 When the result is uncorrectable, d_o SHALL carry the raw (uncorrected) data bits and err_o = 3.
REQ-021 Otherwise err_o SHALL equal deg and d_o = corrected codeword bits [P_D_WIDTH+9:10].
REQ-022 Latency from the accepting edge to out_valid_o rising SHALL be 34 cycles in all cases, error-free words included (unless REQ-030 applies).
REQ-023 In DONE, out_valid_o = 1 and d_o/err_o SHALL be held stable until out_ready_i = 1.
REQ-024 On out_ready_i = 1 in DONE, the FSM SHALL go to IDLE on the next edge; a new codeword is accepted no earlier than the following cycle.
REQ-025 d_o and err_o SHALL be registered and change only on entry to DONE.
REQ-026 Outside DONE, out_valid_o SHALL be 0.
REQ-027 in_valid_i SHALL be ignored outside IDLE.

Reset
REQ-028 With rst_i = 1 at a clock edge, the block SHALL enter IDLE with in_ready_o = 1, out_valid_o = 0, d_o = 0, err_o = 0, and all syndrome, locator, counter and index registers cleared.
REQ-029 Reset SHALL take priority over any handshake on the same edge and SHALL abort an in-flight word with no output produced.

Configuration
REQ-030 With macro BCH_DEC_EARLY_EXIT_EN defined, a word with S1 = S3 = 0 SHALL go SYND -> DONE, giving a latency of 2 cycles and err_o = 0; all other words keep 34 cycles.
REQ-031 With BCH_DEC_EARLY_EXIT_EN undefined, the fixed 34-cycle latency of REQ-022 SHALL apply to every word.

Structure
REQ-032 Package bch_pkg SHALL hold:
- the GF(2^5) width, primitive polynomial and g(x) constants;
- the err_o code constants and the FSM state typedef;
- the gf32 multiply, square and inverse functions.
REQ-033 The syndrome pair (S1, S3) computation SHALL be one combinational sub-module, bch_synd_31, instantiated once.

Verification
REQ-034 The bench SHALL check that cw_i = 31'h00000769 (clean codeword for data 1) gives d_o = 21'h000001, err_o = 0, with out_valid_o rising exactly 34 cycles after acceptance.
REQ-035 The bench SHALL check that cw_i = 31'h00008769 (bit 15 flipped) gives d_o = 21'h000001, err_o = 1.
REQ-036 The bench SHALL check that cw_i = 31'h40000369 (bits 30 and 10 flipped) gives d_o = 21'h000001, err_o = 2.
REQ-037 The bench SHALL check that cw_i = 31'h0000076E (bits 0,1,2 flipped; the locator has no roots) gives err_o = 3, d_o = 21'h000001 (raw).
REQ-038 The bench SHALL check that holding out_ready_i = 0 for 5 cycles in DONE keeps d_o/err_o stable and in_ready_o = 0, with IDLE reached 1 cycle after out_ready_i = 1.
REQ-039 The bench SHALL check that asserting rst_i at CHIEN cycle 10 gives out_valid_o = 0 and in_ready_o = 1 after the edge, and that no result is emitted for the aborted word.
